// File: rtl/mod_147_3_7_heartbeat_fsm_if.sv
// Heartbeat FSM signal bundle: control/status between the heartbeat FSM
// and its surrounding timers / medium monitor.
interface mod_147_3_7_heartbeat_fsm_if #(
  parameter int HB_CNT_W = 8
);
  logic                hb_enable;
  logic                medium_busy;
  logic                hb_timer_done;
  logic                hb_send_timer_done;
  logic                hb_timer_start;
  logic                hb_send_timer_start;
  logic                hb_active;
  logic                hb_dropped;
  logic [HB_CNT_W-1:0] hb_count;

  modport master (
    output hb_enable, medium_busy, hb_timer_done, hb_send_timer_done,
    input  hb_timer_start, hb_send_timer_start, hb_active, hb_dropped, hb_count
  );

  modport slave (
    input  hb_enable, medium_busy, hb_timer_done, hb_send_timer_done,
    output hb_timer_start, hb_send_timer_start, hb_active, hb_dropped, hb_count
  );
endinterface

// File: rtl/mod_147_3_7_heartbeat_fsm.sv
// Heartbeat scheduler: waits for the interval timer, defers while the medium
// is busy (dropping after DEFER_MAX cycles), then runs one send window.
module mod_147_3_7_heartbeat_fsm #(
  parameter int HB_CNT_W  = 8,
  parameter int DEFER_MAX = 255
) (
  input  logic                        clk,
  input  logic                        reset_n,
  mod_147_3_7_heartbeat_fsm_if.slave  hb
);

  localparam int DEFER_W = (DEFER_MAX < 2) ? 1 : $clog2(DEFER_MAX + 1);

  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_ARM_WAIT = 3'd1,
    ST_INTERVAL = 3'd2,
    ST_DEFER    = 3'd3,
    ST_SEND_ARM = 3'd4,
    ST_SEND     = 3'd5
  } state_t;

  state_t              state_q;
  logic [DEFER_W-1:0]  defer_cnt_q;
  logic [DEFER_W-1:0]  defer_cnt_d;
  logic [HB_CNT_W-1:0] hb_count_q;
  logic [HB_CNT_W-1:0] hb_count_d;
  logic                hb_timer_start_q;
  logic                hb_send_timer_start_q;
  logic                hb_active_q;
  logic                hb_dropped_q;
  logic                defer_expired_s;

  assign defer_cnt_d     = defer_cnt_q + DEFER_W'(1);
  assign defer_expired_s = (defer_cnt_q == DEFER_W'(DEFER_MAX - 1));
  // Completed-heartbeat count sticks at all-ones instead of wrapping.
  assign hb_count_d      = (hb_count_q == {HB_CNT_W{1'b1}}) ? hb_count_q
                                                            : hb_count_q + HB_CNT_W'(1);

  // Heartbeat state machine with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q               <= ST_DISABLED;
      defer_cnt_q           <= '0;
      hb_count_q            <= '0;
      hb_timer_start_q      <= 1'b0;
      hb_send_timer_start_q <= 1'b0;
      hb_active_q           <= 1'b0;
      hb_dropped_q          <= 1'b0;
    end else begin
      hb_timer_start_q      <= 1'b0;
      hb_send_timer_start_q <= 1'b0;
      hb_dropped_q          <= 1'b0;
      if (!hb.hb_enable) begin
        // Disable overrides everything, including a coincident timer expiry.
        state_q     <= ST_DISABLED;
        hb_active_q <= 1'b0;
        defer_cnt_q <= '0;
      end else begin
        case (state_q)
          ST_DISABLED: begin
            hb_timer_start_q <= 1'b1;
            state_q          <= ST_ARM_WAIT;
          end
          ST_ARM_WAIT: begin
            if (!hb.hb_timer_done) begin
              state_q <= ST_INTERVAL;
            end
          end
          ST_INTERVAL: begin
            if (hb.hb_timer_done) begin
              if (!hb.medium_busy) begin
                hb_send_timer_start_q <= 1'b1;
                hb_timer_start_q      <= 1'b1;
                hb_active_q           <= 1'b1;
                state_q               <= ST_SEND_ARM;
              end else begin
                defer_cnt_q <= '0;
                state_q     <= ST_DEFER;
              end
            end
          end
          ST_DEFER: begin
            defer_cnt_q <= defer_cnt_d;
            if (!hb.medium_busy) begin
              hb_send_timer_start_q <= 1'b1;
              hb_timer_start_q      <= 1'b1;
              hb_active_q           <= 1'b1;
              state_q               <= ST_SEND_ARM;
            end else if (defer_expired_s) begin
              hb_dropped_q     <= 1'b1;
              hb_timer_start_q <= 1'b1;
              state_q          <= ST_ARM_WAIT;
            end
          end
          ST_SEND_ARM: begin
            // Send-done may still be stale from the previous window.
            hb_active_q <= 1'b1;
            if (!hb.hb_send_timer_done) begin
              state_q <= ST_SEND;
            end
          end
          ST_SEND: begin
            if (hb.hb_send_timer_done) begin
              hb_active_q <= 1'b0;
              hb_count_q  <= hb_count_d;
              state_q     <= ST_ARM_WAIT;
            end
          end
          default: begin
            hb_active_q <= 1'b0;
            state_q     <= ST_DISABLED;
          end
        endcase
      end
    end
  end

  assign hb.hb_timer_start      = hb_timer_start_q;
  assign hb.hb_send_timer_start = hb_send_timer_start_q;
  assign hb.hb_active           = hb_active_q;
  assign hb.hb_dropped          = hb_dropped_q;
  assign hb.hb_count            = hb_count_q;

endmodule

// File: tb/tb_mod_147_3_7_heartbeat_fsm.sv
// Directed bench: DUT A uses default parameters, DUT B uses HB_CNT_W=2 and
// DEFER_MAX=4 for the drop and saturation scenarios.
module tb_mod_147_3_7_heartbeat_fsm;

  logic clk;
  logic reset_n;
  int   n_assert;
  int   n_fail;
  logic any_drop;

  mod_147_3_7_heartbeat_fsm_if #(.HB_CNT_W(8)) if_a ();
  mod_147_3_7_heartbeat_fsm_if #(.HB_CNT_W(2)) if_b ();

  mod_147_3_7_heartbeat_fsm #(.HB_CNT_W(8), .DEFER_MAX(255)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .hb      (if_a)
  );

  mod_147_3_7_heartbeat_fsm #(.HB_CNT_W(2), .DEFER_MAX(4)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .hb      (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    any_drop = 1'b0;
    reset_n  = 1'b0;
    if_a.hb_enable = 1'b0; if_a.medium_busy = 1'b0;
    if_a.hb_timer_done = 1'b0; if_a.hb_send_timer_done = 1'b0;
    if_b.hb_enable = 1'b0; if_b.medium_busy = 1'b0;
    if_b.hb_timer_done = 1'b0; if_b.hb_send_timer_done = 1'b0;
    #1;
    chk1("rst_a_active", if_a.hb_active, 1'b0);
    chk1("rst_a_tstart", if_a.hb_timer_start, 1'b0);
    chk1("rst_a_sstart", if_a.hb_send_timer_start, 1'b0);
    chk1("rst_a_dropped", if_a.hb_dropped, 1'b0);
    chkn("rst_a_count", if_a.hb_count, 8'd0);
    chkn("rst_b_count", 8'(if_b.hb_count), 8'd0);

    // Enable while reset still held: no pulse until reset releases.
    if_a.hb_enable = 1'b1;
    tick();
    chk1("rst_hold_tstart", if_a.hb_timer_start, 1'b0);
    reset_n = 1'b1;
    tick();
    chk1("first_edge_tstart", if_a.hb_timer_start, 1'b1);
    chk1("first_edge_active", if_a.hb_active, 1'b0);
    tick();
    chk1("tstart_one_cycle", if_a.hb_timer_start, 1'b0);
    repeat (10) begin
      tick();
      chk1("interval_idle", if_a.hb_active, 1'b0);
    end

    // Expiry with idle medium starts the heartbeat.
    if_a.hb_timer_done = 1'b1;
    tick();
    chk1("send_sstart", if_a.hb_send_timer_start, 1'b1);
    chk1("send_tstart", if_a.hb_timer_start, 1'b1);
    chk1("send_active", if_a.hb_active, 1'b1);
    if_a.hb_timer_done = 1'b0;
    tick();
    chk1("sstart_one_cycle", if_a.hb_send_timer_start, 1'b0);
    chk1("tstart_not_twice", if_a.hb_timer_start, 1'b0);
    chk1("arm_active", if_a.hb_active, 1'b1);
    tick();
    chk1("send_hold_active", if_a.hb_active, 1'b1);
    chkn("send_hold_count", if_a.hb_count, 8'd0);
    if_a.hb_send_timer_done = 1'b1;
    tick();
    chk1("send_end_active", if_a.hb_active, 1'b0);
    chkn("send_end_count", if_a.hb_count, 8'd1);
    if_a.hb_send_timer_done = 1'b0;
    tick();

    // Busy medium defers the heartbeat for 20 cycles.
    if_a.medium_busy = 1'b1;
    if_a.hb_timer_done = 1'b1;
    tick();
    chk1("defer_active", if_a.hb_active, 1'b0);
    chk1("defer_sstart", if_a.hb_send_timer_start, 1'b0);
    chk1("defer_tstart", if_a.hb_timer_start, 1'b0);
    if_a.hb_timer_done = 1'b0;
    repeat (19) begin
      tick();
      chk1("busy_no_send", if_a.hb_active, 1'b0);
      any_drop = any_drop | if_a.hb_dropped;
    end
    if_a.medium_busy = 1'b0;
    tick();
    chk1("deferred_active", if_a.hb_active, 1'b1);
    chk1("deferred_sstart", if_a.hb_send_timer_start, 1'b1);
    chk1("deferred_tstart", if_a.hb_timer_start, 1'b1);
    any_drop = any_drop | if_a.hb_dropped;
    chk1("never_dropped", any_drop, 1'b0);
    tick();
    if_a.hb_send_timer_done = 1'b1;
    tick();
    chkn("deferred_count", if_a.hb_count, 8'd2);
    if_a.hb_send_timer_done = 1'b0;

    // Stale interval done is ignored until it drops and rises again.
    if_a.hb_timer_done = 1'b1;
    repeat (3) begin
      tick();
      chk1("stale_done_active", if_a.hb_active, 1'b0);
    end
    if_a.hb_timer_done = 1'b0;
    tick();
    if_a.hb_timer_done = 1'b1;
    tick();
    chk1("redone_active", if_a.hb_active, 1'b1);

    // Disable during a heartbeat, then re-enable with done held high.
    if_a.hb_enable = 1'b0;
    tick();
    chk1("disable_active", if_a.hb_active, 1'b0);
    chk1("disable_sstart", if_a.hb_send_timer_start, 1'b0);
    chk1("disable_tstart", if_a.hb_timer_start, 1'b0);
    chkn("disable_count", if_a.hb_count, 8'd2);
    if_a.hb_enable = 1'b1;
    tick();
    chk1("reenable_tstart", if_a.hb_timer_start, 1'b1);
    tick();
    chk1("done_after_start_tstart", if_a.hb_timer_start, 1'b0);
    chk1("done_after_start_active", if_a.hb_active, 1'b0);
    tick();
    chk1("done_held_active", if_a.hb_active, 1'b0);
    if_a.hb_timer_done = 1'b0;
    tick();
    if_a.hb_timer_done = 1'b1;
    if_a.hb_enable = 1'b0;
    tick();
    chk1("disable_wins_active", if_a.hb_active, 1'b0);
    chk1("disable_wins_sstart", if_a.hb_send_timer_start, 1'b0);
    chk1("disable_wins_tstart", if_a.hb_timer_start, 1'b0);
    if_a.hb_timer_done = 1'b0;

    // DUT B: drop after four busy defer cycles.
    if_b.hb_enable = 1'b1;
    tick();
    chk1("b_first_tstart", if_b.hb_timer_start, 1'b1);
    tick();
    if_b.medium_busy = 1'b1;
    if_b.hb_timer_done = 1'b1;
    tick();
    if_b.hb_timer_done = 1'b0;
    repeat (3) begin
      tick();
      chk1("b_defer_no_drop", if_b.hb_dropped, 1'b0);
    end
    tick();
    chk1("b_dropped", if_b.hb_dropped, 1'b1);
    chk1("b_drop_tstart", if_b.hb_timer_start, 1'b1);
    chk1("b_drop_active", if_b.hb_active, 1'b0);
    chkn("b_drop_count", 8'(if_b.hb_count), 8'd0);
    tick();
    chk1("b_drop_one_cycle", if_b.hb_dropped, 1'b0);
    chk1("b_drop_tstart_end", if_b.hb_timer_start, 1'b0);
    if_b.medium_busy = 1'b0;

    // Five heartbeats on a 2-bit counter saturate at 3.
    for (int k = 1; k <= 5; k++) begin
      if_b.hb_timer_done = 1'b1;
      tick();
      chk1("b_hb_active", if_b.hb_active, 1'b1);
      if_b.hb_timer_done = 1'b0;
      tick();
      if_b.hb_send_timer_done = 1'b1;
      tick();
      chkn("b_hb_count", 8'(if_b.hb_count), (k < 3) ? 8'(k) : 8'd3);
      if_b.hb_send_timer_done = 1'b0;
      tick();
    end
    chkn("b_count_sat", 8'(if_b.hb_count), 8'd3);

    // Asynchronous reset in the middle of SEND.
    if_b.hb_timer_done = 1'b1;
    tick();
    if_b.hb_timer_done = 1'b0;
    tick();
    chk1("b_midsend_active", if_b.hb_active, 1'b1);
    #3;
    reset_n = 1'b0;
    #1;
    chk1("b_async_clear_active", if_b.hb_active, 1'b0);
    chkn("b_async_clear_count", 8'(if_b.hb_count), 8'd0);
    chkn("a_async_clear_count", if_a.hb_count, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
